// File: rtl/sram_wb_arbiter_if.sv
// Wishbone classic (non-pipelined) requester bus, one instance per master.
// The master modport drives the request; the slave modport returns data and ack.
interface sram_wb_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/sram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter and sequencer for the RW port of the
// sky130 1 KiB SRAM macro: IDLE -> CMD -> (CAPT for reads) -> ACK -> IDLE.
module sram_wb_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_wb_arbiter_if.slave    m0,
  sram_wb_arbiter_if.slave    m1,
  output logic                sram_csb0,
  output logic                sram_web0,
  output logic [7:0]          sram_wmask0,
  output logic [AW-1:0]       sram_addr0,
  output logic [DW-1:0]       sram_din0,
  input  logic [DW-1:0]       sram_dout0,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {IDLE, CMD, CAPT, ACK} state_t;

  state_t          state_q, state_d;
  logic            win_q;      // 0 = m0, 1 = m1
  logic            last_q;     // last winner, resets to m1 so m0 wins first contention
  logic            abort_q;
  logic            we_q;
  logic [DW/8-1:0] sel_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic [DW-1:0]   rdata_q;

  logic req0, req1, win_d, win_cyc;
  logic ack0, ack1;

  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;
  assign win_d   = (req0 & req1) ? ~last_q : req1;
  assign win_cyc = win_q ? m1.cyc : m0.cyc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            win_q   <= win_d;
            abort_q <= 1'b0;
            if (win_d) begin
              we_q   <= m1.we;
              sel_q  <= m1.sel;
              addr_q <= m1.adr;
              din_q  <= m1.dat_w;
            end else begin
              we_q   <= m0.we;
              sel_q  <= m0.sel;
              addr_q <= m0.adr;
              din_q  <= m0.dat_w;
            end
          end
        end
        CMD: begin
          if (!win_cyc) abort_q <= 1'b1;
        end
        CAPT: begin
          if (!win_cyc) abort_q <= 1'b1;
          rdata_q <= sram_dout0;
        end
        ACK: begin
          last_q <= win_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    grant       = 2'b00;
    ack0        = 1'b0;
    ack1        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) state_d = CMD;
      end
      CMD: begin
        sram_csb0   = 1'b0;
        sram_web0   = ~we_q;
        sram_wmask0 = 8'(sel_q);
        grant       = {win_q, ~win_q};
        state_d     = we_q ? ACK : CAPT;
      end
      CAPT: begin
        sram_csb0 = 1'b0;
        grant     = {win_q, ~win_q};
        state_d   = ACK;
      end
      ACK: begin
        grant   = {win_q, ~win_q};
        state_d = IDLE;
        // An abandoned cycle still finishes at the SRAM but is never acked.
        if (!abort_q && win_cyc) begin
          ack0 = ~win_q;
          ack1 = win_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_addr0 = addr_q;
  assign sram_din0  = din_q;
  assign m0.ack     = ack0;
  assign m1.ack     = ack1;
  assign m0.dat_r   = rdata_q;
  assign m1.dat_r   = rdata_q;

endmodule
